// File: rtl/hebb_pkg.sv
// Shared constants and types for the Hebbian link-table trainer.
// N     : neuron count (5x5 grid), link table depth N*N
// NPAT  : maximum stored patterns; keeps |w| <= NPAT so WW-bit weights never saturate
// WW    : signed weight width
// AW    : link address width
// IW    : neuron index width, CW : pattern counter width, SW : slot index width
package hebb_pkg;
  localparam int N     = 25;
  localparam int DEPTH = N * N;
  localparam int NPAT  = 4;
  localparam int WW    = 8;
  localparam int AW    = 10;
  localparam int IW    = 5;
  localparam int CW    = 4;
  localparam int SW    = (NPAT > 1) ? $clog2(NPAT) : 1;

  typedef enum logic {IDLE, GEN} state_e;

  typedef logic [NPAT-1:0][N-1:0] pat_store_t;
endpackage

// File: rtl/hebb_agree_count.sv
// Counts stored patterns in which neuron i and neuron j carry the same bit.
// Only slots below pat_count take part; unused slots are don't-care.
// Ports: store (pattern slots), pat_count, i, j in; agree (0..NPAT) out.
import hebb_pkg::*;

module hebb_agree_count (
  input  pat_store_t        store,
  input  logic [CW-1:0]     pat_count,
  input  logic [IW-1:0]     i,
  input  logic [IW-1:0]     j,
  output logic [CW-1:0]     agree
);

  logic [NPAT-1:0] hit;

  generate
    for (genvar p = 0; p < NPAT; p++) begin : g_slot
      assign hit[p] = (CW'(p) < pat_count) && (store[p][i] == store[p][j]);
    end
  endgenerate

  always_comb begin
    agree = '0;
    for (int p = 0; p < NPAT; p++) agree = agree + CW'(hit[p]);
  end

endmodule

// File: rtl/hebb_link_trainer.sv
// Builds the N*N signed link table of a Hopfield recall engine by Hebbian rule
// and streams it, row-major, over a ready/valid write port.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   pat_valid/pat_data/pat_ready : pattern load (IDLE only, up to NPAT)
//   clear                    : drop all stored patterns (IDLE only)
//   start                    : pulse, begin weight generation
//   w_we/w_ready/w_addr/w_data : link memory write port (held under backpressure)
//   busy, done               : generation in progress / one-cycle completion pulse
//   pat_count                : number of stored patterns
import hebb_pkg::*;

module hebb_link_trainer (
  input  logic          clk,
  input  logic          rst,
  input  logic          pat_valid,
  input  logic [N-1:0]  pat_data,
  output logic          pat_ready,
  input  logic          clear,
  input  logic          start,
  output logic          w_we,
  input  logic          w_ready,
  output logic [AW-1:0] w_addr,
  output logic [WW-1:0] w_data,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] pat_count
);

  state_e        state_q, state_d;
  pat_store_t    store_q, store_d;
  logic [CW-1:0] pc_q, pc_d;
  logic [IW-1:0] i_q, i_d, j_q, j_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [WW-1:0] data_q, data_d;
  logic          we_q, we_d, busy_q, busy_d, done_q, done_d;
  logic          load_w;
  logic [CW-1:0] agree;
  logic [WW-1:0] w_calc;

  // Agreement is evaluated on the *next* (i,j) so the weight is registered
  // together with the address it belongs to.
  hebb_agree_count u_agree (
    .store     (store_q),
    .pat_count (pc_q),
    .i         (i_d),
    .j         (j_d),
    .agree     (agree)
  );

  // w = agree - disagree = 2*A - pat_count; diagonal forced to zero.
  always_comb begin
    w_calc = '0;
    if (i_d != j_d)
      w_calc = {{(WW-CW-1){1'b0}}, agree, 1'b0} - {{(WW-CW){1'b0}}, pc_q};
  end

  assign pat_ready = (state_q == IDLE) && (pc_q < CW'(NPAT));

  always_comb begin
    state_d = state_q;
    store_d = store_q;
    pc_d    = pc_q;
    i_d     = i_q;
    j_d     = j_q;
    addr_d  = addr_q;
    we_d    = we_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    load_w  = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear) begin
          pc_d = '0;
        end else if (pat_valid && pat_ready) begin
          store_d[pc_q[SW-1:0]] = pat_data;
          pc_d = pc_q + 1'b1;
        end
        if (start) begin
          state_d = GEN;
          busy_d  = 1'b1;
          we_d    = 1'b1;
          i_d     = '0;
          j_d     = '0;
          addr_d  = '0;
          load_w  = 1'b1;
        end
      end
      GEN: begin
        if (we_q && w_ready) begin
          if (addr_q == AW'(DEPTH-1)) begin
            state_d = IDLE;
            we_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            addr_d = addr_q + 1'b1;
            load_w = 1'b1;
            if (j_q == IW'(N-1)) begin
              j_d = '0;
              i_d = i_q + 1'b1;
            end else begin
              j_d = j_q + 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    data_d = load_w ? w_calc : data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      store_q <= '0;
      pc_q    <= '0;
      i_q     <= '0;
      j_q     <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      store_q <= store_d;
      pc_q    <= pc_d;
      i_q     <= i_d;
      j_q     <= j_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign w_we      = we_q;
  assign w_addr    = addr_q;
  assign w_data    = data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pat_count = pc_q;

endmodule

// File: tb/tb_hebb_link_trainer.sv
module tb_hebb_link_trainer;

  logic        clk = 1'b0;
  logic        rst, pat_valid, clear, start, w_ready;
  logic [24:0] pat_data;
  logic        pat_ready, w_we, busy, done;
  logic [9:0]  w_addr;
  logic [7:0]  w_data;
  logic [3:0]  pat_count;

  hebb_link_trainer dut (
    .clk(clk), .rst(rst), .pat_valid(pat_valid), .pat_data(pat_data),
    .pat_ready(pat_ready), .clear(clear), .start(start), .w_we(w_we),
    .w_ready(w_ready), .w_addr(w_addr), .w_data(w_data), .busy(busy),
    .done(done), .pat_count(pat_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [24:0] model[$];
  int          wmem[625];

  typedef struct {
    int scen;
    int addr;
    int exp;
  } spot_t;
  spot_t spots[$];

  localparam logic [24:0] PAT_A = 25'b0111010011100100001001110;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Hebbian weight from its definition: sum of products of +/-1 states.
  function automatic int ref_w(input int i, input int j);
    int s = 0;
    if (i == j) return 0;
    foreach (model[p]) s += ((model[p][i] ? 1 : -1) * (model[p][j] ? 1 : -1));
    return s;
  endfunction

  task automatic load_pat(input logic [24:0] p);
    bit exp_rdy;
    exp_rdy = model.size() < 4;
    check("pat_ready_before_load", pat_ready, exp_rdy);
    pat_valid = 1'b1;
    pat_data  = p;
    @(negedge clk);
    pat_valid = 1'b0;
    if (exp_rdy) model.push_back(p);
    check("pat_count_after_load", pat_count, model.size());
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model.delete();
    check("pat_count_after_clear", pat_count, 0);
    check("pat_ready_after_clear", pat_ready, 1);
  endtask

  // Starts generation and follows it cycle by cycle against the model.
  // bp: random backpressure plus ignored start/clear noise during GEN.
  // abort_at >= 0: assert reset when that address is on the port.
  task automatic run_gen(input bit bp, input int abort_at, input bit with_pat,
                         input logic [24:0] p);
    int n = 0, c, addr_err = 0, data_err = 0, stall_err = 0;
    bit prev_stall = 0, seen_done = 0, aborted = 0;
    logic [9:0] pa = '0;
    logic [7:0] pd = '0;
    foreach (wmem[k]) wmem[k] = 999;
    start = 1'b1;
    if (with_pat) begin pat_valid = 1'b1; pat_data = p; end
    @(negedge clk);
    start = 1'b0;
    pat_valid = 1'b0;
    if (with_pat && model.size() < 4) model.push_back(p);
    check("busy_after_start", busy, 1);
    for (c = 0; c < 5000; c++) begin
      start = 1'b0;
      clear = 1'b0;
      if (done) begin seen_done = 1; break; end
      if (prev_stall && (w_addr != pa || w_data != pd)) stall_err++;
      if (!w_we) addr_err++;
      else begin
        if (int'(w_addr) != n) addr_err++;
        if (int'($signed(w_data)) != ref_w(n / 25, n % 25)) data_err++;
      end
      if (abort_at >= 0 && w_we && n == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_w_we", w_we, 0);
        check("abort_busy", busy, 0);
        check("abort_pat_count", pat_count, 0);
        model.delete();
        for (int k = 0; k < 8; k++) begin
          if (done || w_we) seen_done = 1;
          @(negedge clk);
        end
        check("abort_no_done_or_write", seen_done, 0);
        aborted = 1;
        break;
      end
      w_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bp) begin
        start = ($urandom_range(0, 15) == 0);
        clear = ($urandom_range(0, 15) == 0);
      end
      if (w_we && w_ready) begin
        wmem[n] = int'($signed(w_data));
        n++;
      end
      prev_stall = w_we && !w_ready;
      pa = w_addr;
      pd = w_data;
      @(negedge clk);
    end
    start = 1'b0;
    clear = 1'b0;
    w_ready = 1'b1;
    if (aborted) return;
    check("done_seen", seen_done, 1);
    check("transfer_count", n, 625);
    check("addr_order_errors", addr_err, 0);
    check("weight_errors", data_err, 0);
    check("stall_hold_errors", stall_err, 0);
    if (!bp) check("done_latency", c, 625);
    check("w_we_at_done", w_we, 0);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("busy_after_done", busy, 0);
    check("pat_count_kept", pat_count, model.size());
  endtask

  task automatic check_spots(input int scen);
    foreach (spots[k])
      if (spots[k].scen == scen)
        check($sformatf("w_s%0d_addr%0d", scen, spots[k].addr), wmem[spots[k].addr],
              spots[k].exp);
  endtask

  initial begin
    spots = '{
      '{1, 1, -1}, '{1, 27, 1}, '{1, 0, 0}, '{1, 26, 0}, '{1, 312, 0}, '{1, 624, 0},
      '{2, 27, 3}, '{2, 1, -1}, '{2, 0, 0},
      '{3, 1, 0}, '{3, 27, 0}, '{3, 623, 0}
    };
    rst = 1'b1; pat_valid = 1'b0; pat_data = '0; clear = 1'b0; start = 1'b0;
    w_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_pat_ready", pat_ready, 1);
    check("rst_pat_count", pat_count, 0);
    check("rst_w_we", w_we, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    @(negedge clk);

    // single pattern, full-rate stream
    load_pat(PAT_A);
    run_gen(0, -1, 0, '0);
    check_spots(1);

    // pattern twice plus all-ones, under backpressure
    do_clear();
    load_pat(PAT_A);
    load_pat(PAT_A);
    load_pat(25'h1FFFFFF);
    check("pat_count_three", pat_count, 3);
    run_gen(1, -1, 0, '0);
    check_spots(2);

    // capacity: 4th accepted, 5th refused
    load_pat(25'h0AAAAAA);
    check("pat_ready_full", pat_ready, 0);
    load_pat(25'h1555555);
    check("pat_count_full", pat_count, 4);

    // clear wins over a simultaneous transfer, then empty store gives zeros
    clear = 1'b1; pat_valid = 1'b1; pat_data = 25'h123456;
    @(negedge clk);
    clear = 1'b0; pat_valid = 1'b0; model.delete();
    check("clear_priority", pat_count, 0);
    load_pat(25'h00F0F0F);
    do_clear();
    run_gen(0, -1, 0, '0);
    check_spots(3);

    // random stores, start coinciding with a pattern transfer
    for (int r = 0; r < 4; r++) begin
      do_clear();
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) load_pat(25'($urandom));
      run_gen(1'($urandom_range(0, 1)), -1, 1, 25'($urandom));
    end

    // reset in the middle of a stream
    do_clear();
    load_pat(PAT_A);
    load_pat(25'h0F0F0F0);
    run_gen(1, 300, 0, '0);
    check("after_abort_pat_ready", pat_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
